scoreboard_display_scan: RTL
============================

// Module: scoreboard_display_scan
// PURPOSE
//  Multiplexed 7-segment display driver for the scoreboard controller's digit outputs.
//  Accepts the six per-digit segment buses and Done; drives one shared common-anode
//  segment bus plus six active-low digit enables, one digit lit at a time.
//  Sits between the scoreboard controller and the board display pins.
// PARAMETERS
//  REFRESH_DIV   50000  clk cycles per digit slot (>=2)
//  GUARD_CYCLES  2      blank cycles at start of each slot, anti-ghosting (0..REFRESH_DIV-1)
//  BLINK_FRAMES  64     full frames per blink period (even, >=2)
// PORTS
//  clk            in   1  system clock, rising edge
//  rst_n          in   1  asynchronous active-low reset
//  done           in   1  game-over flag from scoreboard controller
//  seg7_points_2  in   7  points hundreds pattern, bit=1 segment on (digit 0, leftmost)
//  seg7_points_1  in   7  points tens (digit 1)
//  seg7_points_0  in   7  points units (digit 2)
//  seg7_timer_1   in   7  timer tens (digit 3)
//  seg7_timer_0   in   7  timer units (digit 4)
//  seg7_level     in   7  level (digit 5, rightmost)
//  seg_n          out  7  shared segment drive, active-low
//  an_n           out  6  digit enables, active-low, an_n[k] = digit k
//  frame_start    out  1  one-cycle pulse at snapshot capture
// BEHAVIOUR
//  - All outputs registered; no combinational path from inputs to outputs.
//  - Reset (async, rst_n=0): an_n=6'h3F, seg_n=7'h7F, frame_start=0; slot cnt=0, idx=0,
//    snapshot=0, frame cnt=0. Mid-operation reset blanks immediately and restarts at slot 0.
//  - After reset release: cycle 0 = slot 0, cycle 0. Slot k occupies REFRESH_DIV cycles;
//    idx 0..5, wraps 5->0. One frame = 6*REFRESH_DIV cycles.
//  - States per slot: GUARD (first GUARD_CYCLES cycles): an_n=6'h3F, seg_n=7'h7F.
//    ON (remaining cycles): an_n[idx]=0 (others 1), seg_n=~snap[idx].
//    GUARD_CYCLES=0: ON for whole slot, no GUARD cycles.
//  - Outputs reflect the slot/state of the current cycle, registered one clk after counters.
//  - Snapshot: all six buses and done captured together on slot 0, cycle 0.
//    frame_start=1 on exactly that cycle. Input changes mid-frame appear next frame only
//    (no tearing).
//  - Frame counter increments at each frame_start, wraps at BLINK_FRAMES-1 -> 0.
//  - Illegal parameters (GUARD_CYCLES>=REFRESH_DIV, REFRESH_DIV<2, odd BLINK_FRAMES):
//    elaboration-time $error.
// CONFIGURATION
//  SCOREBOARD_DONE_BLINK_EN defined: with snapshot done=1, ON cycles in frames
//    frame_cnt >= BLINK_FRAMES/2 are forced to GUARD outputs (whole display blinks,
//    50% duty). done=0 restores at the next frame.
//  Undefined: done is ignored (port kept); display always lit per BEHAVIOUR.
// STRUCTURE
//  scoreboard_pkg: NUM_DIGITS=6, SEG_W=7, SEG_OFF_N=7'h7F, AN_OFF_N=6'h3F,
//    digit index localparams DIG_PTS2..DIG_LEVEL; used by controller and this block.
//  Sub-module scoreboard_refresh_tick: slot counter 0..REFRESH_DIV-1 with wrap pulse
//    and in_guard flag.
// TESTING (REFRESH_DIV=4, GUARD_CYCLES=1, BLINK_FRAMES=4 unless noted)
//  1 rst_n=0 for 3 clks -> an_n=6'h3F, seg_n=7'h7F, frame_start=0; release ->
//    frame_start=1 on the first cycle only, then every 24 cycles.
//  2 Inputs 06,5B,4F,66,6D,7D (digits 0..5) -> per slot 1 blank cycle, then 3 cycles
//    with an_n=~(1<<k) and seg_n=~pattern (e.g. slot 0: an_n=6'h3E, seg_n=7'h79).
//  3 seg7_points_0 3F->06 during slot 1 -> slot 2 shows seg_n=7'h40 this frame and
//    seg_n=7'h79 next frame.
//  4 GUARD_CYCLES=0 -> no blank cycles; an_n never 6'h3F after the first frame_start.
//  5 With SCOREBOARD_DONE_BLINK_EN, done=1 -> frames alternate 2 lit / 2 all-blank;
//    without the macro -> all frames lit.
//  6 rst_n pulsed low mid slot 3 -> outputs blank without waiting for clk;
//    after release, slot 0 restarts with frame_start=1.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared definitions for the scoreboard controller and the display scan block:
// digit count, segment bus width, blank drive levels, digit indices and the
// one-cold digit-enable helper.
package scoreboard_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int SEG_W      = 7;
  localparam int IDX_W      = 3;

  typedef logic [SEG_W-1:0]      seg_t;
  typedef logic [NUM_DIGITS-1:0] an_t;
  typedef logic [IDX_W-1:0]      idx_t;

  localparam seg_t SEG_OFF_N = 7'h7F;
  localparam an_t  AN_OFF_N  = 6'h3F;

  // Digit positions, leftmost (0) to rightmost (5)
  localparam idx_t DIG_PTS2  = 3'd0;
  localparam idx_t DIG_PTS1  = 3'd1;
  localparam idx_t DIG_PTS0  = 3'd2;
  localparam idx_t DIG_TMR1  = 3'd3;
  localparam idx_t DIG_TMR0  = 3'd4;
  localparam idx_t DIG_LEVEL = 3'd5;

  // Active-low enable with only digit i pulled low
  function automatic an_t an_onecold(input idx_t i);
    return AN_OFF_N & ~(an_t'(1) << i);
  endfunction

endpackage

// File: rtl/scoreboard_refresh_tick.sv
// Slot timer for the display scan: counts 0..REFRESH_DIV-1, flags the last
// cycle of a slot (wrap) and the leading anti-ghosting guard cycles.
module scoreboard_refresh_tick #(
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_first,
  output logic wrap,
  output logic in_guard
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] cnt_p0;

  assign slot_first = (cnt_p0 == '0);
  assign wrap       = (cnt_p0 == CNT_W'(REFRESH_DIV - 1));

  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (cnt_p0 < CNT_W'(GUARD_CYCLES));
    end
  endgenerate

  // Free-running slot cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0 <= '0;
    end else if (wrap) begin
      cnt_p0 <= '0;
    end else begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

endmodule

// File: rtl/scoreboard_display_scan.sv
// Multiplexed common-anode 7-segment driver for the scoreboard: snapshots the
// six digit buses once per frame and lights one digit per slot, with blank
// guard cycles at the start of each slot.
// Optional feature macro SCOREBOARD_DONE_BLINK_EN: when the captured done flag
// is set, the second half of every blink period is blanked.
module scoreboard_display_scan
  import scoreboard_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             done,
  input  logic [SEG_W-1:0] seg7_points_2,
  input  logic [SEG_W-1:0] seg7_points_1,
  input  logic [SEG_W-1:0] seg7_points_0,
  input  logic [SEG_W-1:0] seg7_timer_1,
  input  logic [SEG_W-1:0] seg7_timer_0,
  input  logic [SEG_W-1:0] seg7_level,
  output logic [SEG_W-1:0] seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic             frame_start
);

  localparam int FRAME_W = $clog2(BLINK_FRAMES);

  localparam logic [0:0] ST_GUARD = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  generate
    if (REFRESH_DIV < 2) begin : g_bad_div
      $error("REFRESH_DIV must be at least 2");
    end
    if (GUARD_CYCLES < 0 || GUARD_CYCLES >= REFRESH_DIV) begin : g_bad_guard
      $error("GUARD_CYCLES must be in 0..REFRESH_DIV-1");
    end
    if (BLINK_FRAMES < 2 || (BLINK_FRAMES % 2) != 0) begin : g_bad_blink
      $error("BLINK_FRAMES must be even and at least 2");
    end
  endgenerate

  logic slot_first, slot_wrap, in_guard;

  scoreboard_refresh_tick #(
    .REFRESH_DIV  (REFRESH_DIV),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_first (slot_first),
    .wrap       (slot_wrap),
    .in_guard   (in_guard)
  );

  // ---- stage p0: digit index, frame counter, snapshot ----
  idx_t                          idx_p0;
  logic [FRAME_W-1:0]            frame_cnt_p0;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] snap_p0;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] bus_in;
  logic [NUM_DIGITS-1:0][SEG_W-1:0] snap_cur;
  logic                          frame_first;
  logic                          frame_last;
  logic                          blank_frame;
  logic [0:0]                    state;

  assign frame_first = slot_first && (idx_p0 == DIG_PTS2);
  assign frame_last  = slot_wrap && (idx_p0 == DIG_LEVEL);

  always_comb begin
    bus_in           = '0;
    bus_in[DIG_PTS2]  = seg7_points_2;
    bus_in[DIG_PTS1]  = seg7_points_1;
    bus_in[DIG_PTS0]  = seg7_points_0;
    bus_in[DIG_TMR1]  = seg7_timer_1;
    bus_in[DIG_TMR0]  = seg7_timer_0;
    bus_in[DIG_LEVEL] = seg7_level;
  end

  // The capture cycle itself already displays the freshly captured data
  assign snap_cur = frame_first ? bus_in : snap_p0;

  // Digit slot index, advances on each slot wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_p0 <= DIG_PTS2;
    end else if (slot_wrap) begin
      idx_p0 <= (idx_p0 == DIG_LEVEL) ? DIG_PTS2 : idx_p0 + idx_t'(1);
    end
  end

  // Frame counter steps at the end of a frame so the new value holds from frame_start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_p0 <= '0;
    end else if (frame_last) begin
      frame_cnt_p0 <= (frame_cnt_p0 == FRAME_W'(BLINK_FRAMES - 1)) ? '0
                                                                    : frame_cnt_p0 + FRAME_W'(1);
    end
  end

  // Whole-frame snapshot of the digit buses, taken on slot 0 cycle 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_p0 <= '0;
    end else if (frame_first) begin
      snap_p0 <= bus_in;
    end
  end

`ifdef SCOREBOARD_DONE_BLINK_EN
  logic done_p0;
  logic done_cur;

  assign done_cur    = frame_first ? done : done_p0;
  assign blank_frame = done_cur && (frame_cnt_p0 >= FRAME_W'(BLINK_FRAMES / 2));

  // Game-over flag, captured with the digit snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_p0 <= 1'b0;
    end else if (frame_first) begin
      done_p0 <= done;
    end
  end
`else
  logic unused_blink;

  assign blank_frame  = 1'b0;
  assign unused_blink = ^{done, frame_cnt_p0};
`endif

  assign state = (in_guard || blank_frame) ? ST_GUARD : ST_ON;

  // ---- stage p1: registered pin drive ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n        <= AN_OFF_N;
      seg_n       <= SEG_OFF_N;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_first;
      if (state == ST_ON) begin
        an_n  <= an_onecold(idx_p0);
        seg_n <= ~snap_cur[idx_p0];
      end else begin
        an_n  <= AN_OFF_N;
        seg_n <= SEG_OFF_N;
      end
    end
  end

endmodule
